sum_control_unit: RTL and testbench

SUM_CONTROL_UNIT -- requirements
Module: sum_control_unit

---
 rtl/sum_control_unit.sv | 98 +++++++++
 tb/tb_sum_control_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_control_unit.sv
// Control FSM for the summing datapath: clears A/Sum, loops CHECK/ADD while A is below bound, publishes.
// Optional watchdog abort enabled by defining SUM_CU_WATCHDOG_EN.
module sum_control_unit #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       ALt10,
    output logic       ASrcMuxSel,
    output logic       ALoad,
    output logic       StateRegEn,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] iter_cnt,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        CHECK   = 3'd2,
        ADD     = 3'd3,
        PUBLISH = 3'd4,
        DONE    = 3'd5,
        ABORT   = 3'd6
    } state_t;

    state_t state;
    state_t nxt;
    logic   timeout_hit;

`ifdef SUM_CU_WATCHDOG_EN
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);
    logic [7:0] wd_cnt;
    assign timeout_hit = (wd_cnt >= TIMEOUT_LIM);
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = start ? CLEAR : IDLE;
            CLEAR:   nxt = CHECK;
            CHECK:   nxt = timeout_hit ? ABORT : (ALt10 ? ADD : PUBLISH);
            ADD:     nxt = timeout_hit ? ABORT : CHECK;
            PUBLISH: nxt = DONE;
            DONE:    nxt = IDLE;
            ABORT:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            state_dbg  <= '0;
            ASrcMuxSel <= 1'b0;
            ALoad      <= 1'b0;
            StateRegEn <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            iter_cnt   <= '0;
`ifdef SUM_CU_WATCHDOG_EN
            wd_cnt     <= '0;
            err        <= 1'b0;
`endif
        end else begin
            state      <= nxt;
            state_dbg  <= nxt;
            ASrcMuxSel <= (nxt == ADD);
            ALoad      <= (nxt == CLEAR) || (nxt == ADD);
            StateRegEn <= (nxt == PUBLISH);
            busy       <= (nxt != IDLE);
            done       <= (nxt == DONE) || (nxt == ABORT);
            if (nxt == CLEAR)
                iter_cnt <= '0;
            else if (nxt == ADD && iter_cnt != '1)
                iter_cnt <= iter_cnt + 8'd1;
`ifdef SUM_CU_WATCHDOG_EN
            // Counter value equals the number of cycles spent outside IDLE, including the current one.
            if (nxt == IDLE)
                wd_cnt <= '0;
            else if (wd_cnt != '1)
                wd_cnt <= wd_cnt + 8'd1;
            if (nxt == ABORT)
                err <= 1'b1;
            else if (nxt == CLEAR)
                err <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_sum_control_unit.sv
// Bench for sum_control_unit driving a behavioural 8-bit summing datapath (bound A<11).
module tb_sum_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       ALt10;
    logic       ASrcMuxSel, ALoad, StateRegEn, busy, done, err;
    logic [7:0] iter_cnt;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    // Datapath: A counts up, Sum accumulates the incremented A, out latches Sum on publish.
    logic [7:0] a_reg = '0;
    logic [7:0] sum_reg = '0;
    logic [7:0] out_reg = 8'hA5;
    logic       alt_force = 1'b0;
    logic       dp_clr = 1'b0;

    always @(posedge clk) begin
        if (dp_clr)
            out_reg <= '0;
        else if (StateRegEn)
            out_reg <= sum_reg;
        if (ALoad) begin
            if (ASrcMuxSel) begin
                a_reg   <= a_reg + 8'd1;
                sum_reg <= sum_reg + a_reg + 8'd1;
            end else begin
                a_reg   <= '0;
                sum_reg <= '0;
            end
        end
    end

    assign ALt10 = alt_force | (a_reg < 8'd11);

    sum_control_unit dut (
        .clk(clk), .reset(reset), .start(start), .ALt10(ALt10),
        .ASrcMuxSel(ASrcMuxSel), .ALoad(ALoad), .StateRegEn(StateRegEn),
        .busy(busy), .done(done), .err(err), .iter_cnt(iter_cnt), .state_dbg(state_dbg)
    );

`ifdef SUM_CU_WATCHDOG_EN
    logic       start2 = 1'b0;
    logic       w_asrc, w_aload, w_sre, w_busy, w_done, w_err;
    logic [7:0] w_iter;
    logic [2:0] w_st;
    int         w_sre_cnt = 0;

    sum_control_unit #(.TIMEOUT(10)) wd_dut (
        .clk(clk), .reset(reset), .start(start2), .ALt10(1'b1),
        .ASrcMuxSel(w_asrc), .ALoad(w_aload), .StateRegEn(w_sre),
        .busy(w_busy), .done(w_done), .err(w_err), .iter_cnt(w_iter), .state_dbg(w_st)
    );
`endif

    int checks = 0;
    int fails = 0;
    int done_cnt = 0;
    int sre_cnt = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (done) done_cnt++;
            if (StateRegEn) sre_cnt++;
            check("excl_load_publish", {31'b0, ALoad & StateRegEn}, 32'd0);
            check("asrc_only_in_add", {31'b0, ASrcMuxSel & (state_dbg != 3'd3)}, 32'd0);
`ifdef SUM_CU_WATCHDOG_EN
            if (w_sre) w_sre_cnt++;
`endif
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_done(input string name, input int maxc);
        int n = 0;
        while (done !== 1'b1 && n < maxc) begin
            step();
            n++;
        end
        check(name, {31'b0, done}, 32'd1);
    endtask

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       asrc, aload, sre, bsy, dn;
        logic [7:0] iter;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int cyc;
        int n;
        int d0;
        int s0;

        tbl[0]  = '{1,  3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[1]  = '{2,  3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[2]  = '{3,  3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
        tbl[3]  = '{4,  3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
        tbl[4]  = '{5,  3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2};
        tbl[5]  = '{13, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd6};
        tbl[6]  = '{22, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd10};
        tbl[7]  = '{23, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd11};
        tbl[8]  = '{24, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd11};
        tbl[9]  = '{25, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd11};
        tbl[10] = '{26, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd11};
        tbl[11] = '{27, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd11};

        // Reset state
        step();
        step();
        check("reset_state", {14'b0, state_dbg, ASrcMuxSel, ALoad, StateRegEn, busy, done, err, iter_cnt}, 32'd0);
        reset = 1'b1;
        mon_en = 1'b1;
        step();
        step();
        check("idle_holds", {29'b0, state_dbg}, 32'd0);

        // Single run, cycle-by-cycle against the table
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        for (int i = 0; i < 12; i++) begin
            while (cyc < tbl[i].cyc) begin
                step();
                cyc++;
            end
            check($sformatf("run1_cyc%0d", tbl[i].cyc),
                  {16'b0, state_dbg, ASrcMuxSel, ALoad, StateRegEn, busy, done, iter_cnt},
                  {16'b0, tbl[i].st, tbl[i].asrc, tbl[i].aload, tbl[i].sre, tbl[i].bsy, tbl[i].dn, tbl[i].iter});
        end
        check("run1_out", {24'b0, out_reg}, 32'd66);
        check("run1_err", {31'b0, err}, 32'd0);

        // Start held high: back-to-back runs with one IDLE cycle between
        dp_clr = 1'b1;
        step();
        dp_clr = 1'b0;
        check("out_cleared", {24'b0, out_reg}, 32'd0);
        start = 1'b1;
        for (int r = 0; r < 2; r++) begin
            wait_done($sformatf("b2b_done%0d", r), 40);
            check($sformatf("b2b_out%0d", r), {24'b0, out_reg}, 32'd66);
            dp_clr = 1'b1;
            if (r == 1) start = 1'b0;
            step();
            dp_clr = 1'b0;
            check($sformatf("b2b_idle%0d", r), {29'b0, state_dbg}, 32'd0);
            step();
            check($sformatf("b2b_next%0d", r), {29'b0, state_dbg}, (r == 0) ? 32'd1 : 32'd0);
        end

        // Start pulsed during ADD is ignored
        d0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (state_dbg !== 3'd3 && n < 10) begin
            step();
            n++;
        end
        check("reach_add", {29'b0, state_dbg}, 32'd3);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("ignored_start_done", 40);
        check("ignored_start_iter", {24'b0, iter_cnt}, 32'd11);
        repeat (40) step();
        check("ignored_start_single_done", done_cnt - d0, 32'd1);
        check("ignored_start_idle", {31'b0, busy}, 32'd0);

        // Reset mid-run while in ADD with iter_cnt=5
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!(state_dbg === 3'd3 && iter_cnt === 8'd5) && n < 30) begin
            step();
            n++;
        end
        check("reach_add5", {21'b0, state_dbg, iter_cnt}, {21'b0, 3'd3, 8'd5});
        d0 = done_cnt;
        s0 = sre_cnt;
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("midrun_reset", {19'b0, state_dbg, busy, done, iter_cnt}, 32'd0);
        repeat (40) step();
        check("midrun_no_done", done_cnt - d0, 32'd0);
        check("midrun_no_publish", sre_cnt - s0, 32'd0);
        check("midrun_out_kept", {24'b0, out_reg}, 32'd66);

        // Reset has priority over start
        start = 1'b1;
        reset = 1'b0;
        step();
        check("reset_over_start", {28'b0, state_dbg, busy}, 32'd0);
        reset = 1'b1;
        start = 1'b0;
        step();
        check("reset_over_start_after", {29'b0, state_dbg}, 32'd0);

`ifdef SUM_CU_WATCHDOG_EN
        // Watchdog: TIMEOUT=10 with ALt10 stuck high aborts in cycle 11
        s0 = w_sre_cnt;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        n = 1;
        while (w_st !== 3'd6 && n < 20) begin
            step();
            n++;
        end
        check("wd_abort_cycle", n, 32'd11);
        check("wd_abort_outputs", {25'b0, w_st, w_busy, w_done, w_err, w_sre}, {25'b0, 3'd6, 1'b1, 1'b1, 1'b1, 1'b0});
        step();
        check("wd_idle_err_sticky", {27'b0, w_st, w_done, w_err}, {27'b0, 3'd0, 1'b0, 1'b1});
        step();
        check("wd_err_still_set", {31'b0, w_err}, 32'd1);
        check("wd_no_publish", w_sre_cnt - s0, 32'd0);
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        check("wd_err_cleared", {28'b0, w_st, w_err}, {28'b0, 3'd1, 1'b0});
        reset = 1'b0;
        step();
        reset = 1'b1;
`else
        // No watchdog: ALt10 stuck high keeps looping and saturates iter_cnt
        d0 = done_cnt;
        alt_force = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (600) step();
        check("nowd_iter_sat", {24'b0, iter_cnt}, 32'd255);
        check("nowd_err", {31'b0, err}, 32'd0);
        check("nowd_looping", {31'b0, (state_dbg == 3'd2) || (state_dbg == 3'd3)}, 32'd1);
        check("nowd_no_done", done_cnt - d0, 32'd0);
        reset = 1'b0;
        alt_force = 1'b0;
        step();
        reset = 1'b1;
`endif
        step();
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
